// File: rtl/fwd_pkg.sv
// Shared types and constants for the operand forwarding / hazard unit.
// Holds the forward-select encoding, default sizes and the x0 address.
package fwd_pkg;

  localparam int NUM_STG_DEF = 2;
  localparam int MAX_LAT_DEF = 8;
  localparam int RAW_DEF     = 5;
  localparam int X0          = 0;

  // With the default NUM_STG=2: 0=regfile, 1=MEM, 2=WB, 3=MC bus.
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2,
    FWD_MC  = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/sb_counter_bank.sv
// Per-register countdown bank tracking outstanding multi-cycle writes.
// Ports: clk, rst, ld/ld_idx/ld_val load, zero/one per-entry flags.
module sb_counter_bank #(
  parameter int RAW = 5,
  parameter int CW  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld,
  input  logic [RAW-1:0]        ld_idx,
  input  logic [CW-1:0]         ld_val,
  output logic [(1<<RAW)-1:0]   zero,
  output logic [(1<<RAW)-1:0]   one
);

  localparam int N = 1 << RAW;

  logic [CW-1:0] cnt [N];

  // Entry 0 is never loaded, so it stays at zero.
  // A load wins over the decrement of the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < N; r++) begin
        if (ld && ld_idx == RAW'(r))
          cnt[r] <= ld_val;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - CW'(1);
      end
    end
  end

  always_comb begin
    zero = '0;
    one  = '0;
    for (int r = 0; r < N; r++) begin
      zero[r] = (cnt[r] == '0);
      one[r]  = (cnt[r] == CW'(1));
    end
  end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// Operand forwarding, hazard detection and multi-cycle scoreboard.
// Ports: EX sources, post-EX stage dests, MC issue, store fwd, FWD_SEL/FWD_ST/STALL/SB_BUSY.
module fwd_scoreboard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int NUM_STG = NUM_STG_DEF,
  parameter int RAW     = RAW_DEF,
  parameter int MAX_LAT = MAX_LAT_DEF,
  parameter int SW      = $clog2(NUM_STG+2),
  parameter int CW      = $clog2(MAX_LAT+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC*RAW-1:0] RS_EX,
  input  logic [NUM_SRC-1:0]     RS_USE_EX,
  input  logic [NUM_STG*RAW-1:0] RD_STG,
  input  logic [NUM_STG-1:0]     REGWRITE_STG,
  input  logic [NUM_STG-1:0]     RESVALID_STG,
  input  logic                   MC_ISSUE,
  input  logic [RAW-1:0]         MC_RD,
  input  logic [CW-1:0]          MC_LAT,
  input  logic [RAW-1:0]         RS2_MEM,
  input  logic                   MEMWRITE_MEM,
  input  logic                   MEMREAD_WB,
  output logic [NUM_SRC*SW-1:0]  FWD_SEL,
  output logic                   FWD_ST,
  output logic                   STALL,
  output logic                   SB_BUSY
);

  localparam int NREG = 1 << RAW;

  logic [NREG-1:0]    zero;
  logic [NREG-1:0]    one;
  logic [NREG-1:0]    gt1;
  logic [CW-1:0]      lat;
  logic               ld;
  logic [NUM_SRC-1:0] haz;

  assign gt1 = ~zero & ~one;

  // Latency is clamped into 1..MAX_LAT.
  always_comb begin
    lat = MC_LAT;
    if (MC_LAT > CW'(MAX_LAT))
      lat = CW'(MAX_LAT);
    else if (MC_LAT == '0)
      lat = CW'(1);
  end

  assign ld = MC_ISSUE & ~STALL & (MC_RD != RAW'(X0));

  sb_counter_bank #(
    .RAW (RAW),
    .CW  (CW)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .ld     (ld),
    .ld_idx (MC_RD),
    .ld_val (lat),
    .zero   (zero),
    .one    (one)
  );

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [RAW-1:0] rs;
    logic           used;
    logic           hit;
    logic           rdy;
    logic [SW-1:0]  hk;
    logic [SW-1:0]  sel;

    assign rs   = RS_EX[i*RAW +: RAW];
    assign used = RS_USE_EX[i] & (rs != RAW'(X0));

    // Scan oldest to youngest so the youngest hit overwrites.
    always_comb begin
      hit = 1'b0;
      rdy = 1'b1;
      hk  = '0;
      for (int k = NUM_STG; k >= 1; k--) begin
        if (REGWRITE_STG[k-1] &&
            RD_STG[(k-1)*RAW +: RAW] == rs) begin
          hit = 1'b1;
          rdy = RESVALID_STG[k-1];
          hk  = SW'(k);
        end
      end
    end

    always_comb begin
      sel = SW'(FWD_RF);
      if (used) begin
        if (hit)
          sel = hk;
        else if (one[rs])
          sel = SW'(NUM_STG+1);
      end
    end

    assign haz[i] = used & (hit ? ~rdy : gt1[rs]);
    assign FWD_SEL[i*SW +: SW] = sel;
  end

  // gt1[0] is always clear, so an x0 issue never trips WAW.
  assign STALL = (|haz) | (MC_ISSUE & gt1[MC_RD]);

  assign FWD_ST = MEMWRITE_MEM & MEMREAD_WB &
                  (RD_STG[(NUM_STG-1)*RAW +: RAW] == RS2_MEM) &
                  (RS2_MEM != RAW'(X0));

  assign SB_BUSY = ~&zero;

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Directed self-checking bench for fwd_scoreboard_unit.
// Default parameters: 3 sources, 2 stages, 5-bit regs, MAX_LAT 8.
module tb_fwd_scoreboard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] RS_EX;
  logic [2:0]  RS_USE_EX;
  logic [9:0]  RD_STG;
  logic [1:0]  REGWRITE_STG;
  logic [1:0]  RESVALID_STG;
  logic        MC_ISSUE;
  logic [4:0]  MC_RD;
  logic [3:0]  MC_LAT;
  logic [4:0]  RS2_MEM;
  logic        MEMWRITE_MEM;
  logic        MEMREAD_WB;
  logic [5:0]  FWD_SEL;
  logic        FWD_ST;
  logic        STALL;
  logic        SB_BUSY;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fwd_scoreboard_unit dut (
    .clk          (clk),
    .rst          (rst),
    .RS_EX        (RS_EX),
    .RS_USE_EX    (RS_USE_EX),
    .RD_STG       (RD_STG),
    .REGWRITE_STG (REGWRITE_STG),
    .RESVALID_STG (RESVALID_STG),
    .MC_ISSUE     (MC_ISSUE),
    .MC_RD        (MC_RD),
    .MC_LAT       (MC_LAT),
    .RS2_MEM      (RS2_MEM),
    .MEMWRITE_MEM (MEMWRITE_MEM),
    .MEMREAD_WB   (MEMREAD_WB),
    .FWD_SEL      (FWD_SEL),
    .FWD_ST       (FWD_ST),
    .STALL        (STALL),
    .SB_BUSY      (SB_BUSY)
  );

  function automatic int sel(input int i);
    return int'(FWD_SEL[i*2 +: 2]);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    RS_EX = '0; RS_USE_EX = '0; RD_STG = '0;
    REGWRITE_STG = '0; RESVALID_STG = 2'b11;
    MC_ISSUE = 0; MC_RD = '0; MC_LAT = '0;
    RS2_MEM = '0; MEMWRITE_MEM = 0; MEMREAD_WB = 0;
  endtask

  task automatic src(input int i, input logic [4:0] r, input logic u);
    RS_EX[i*5 +: 5] = r;
    RS_USE_EX[i]    = u;
  endtask

  initial begin
    clr();
    rst = 1;
    tick();
    tick();
    chk("rst_busy", int'(SB_BUSY), 0);
    chk("rst_stall", int'(STALL), 0);
    chk("rst_sel", int'(FWD_SEL), 0);
    chk("rst_st", int'(FWD_ST), 0);
    rst = 0;

    // Mid-flight reset with cnt[5]=3
    tick();
    MC_ISSUE = 1; MC_RD = 5'd5; MC_LAT = 4'd3;
    tick();
    MC_ISSUE = 0;
    #1 chk("pre_rst_busy", int'(SB_BUSY), 1);
    rst = 1;
    tick();
    rst = 0;
    src(0, 5'd5, 1);
    #1;
    chk("midrst_busy", int'(SB_BUSY), 0);
    chk("midrst_stall", int'(STALL), 0);
    chk("midrst_sel0", sel(0), 0);
    tick();
    chk("midrst_sel0_b", sel(0), 0);

    // Priority: youngest stage wins
    clr();
    src(0, 5'd7, 1);
    RD_STG = {5'd7, 5'd7}; REGWRITE_STG = 2'b11;
    #1 chk("prio_both", sel(0), 1);
    REGWRITE_STG = 2'b10;
    #1 chk("prio_stg2", sel(0), 2);

    // Load-use
    clr();
    tick();
    src(1, 5'd3, 1);
    RD_STG = {5'd0, 5'd3}; REGWRITE_STG = 2'b01;
    RESVALID_STG = 2'b00;
    #1 chk("lu_stall", int'(STALL), 1);
    chk("lu_sel1", sel(1), 1);
    RS_USE_EX[1] = 0;
    #1 chk("lu_unused", int'(STALL), 0);
    RS_USE_EX[1] = 1;
    tick();
    RD_STG = {5'd3, 5'd0}; REGWRITE_STG = 2'b10;
    RESVALID_STG = 2'b11;
    #1 chk("lu_clear", int'(STALL), 0);
    chk("lu_sel1_wb", sel(1), 2);

    // MC op x9, latency 4
    clr();
    MC_ISSUE = 1; MC_RD = 5'd9; MC_LAT = 4'd4;
    #1 chk("mc_accept", int'(STALL), 0);
    tick();
    MC_ISSUE = 0;
    src(0, 5'd9, 1);
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("mc_stall%0d", c), int'(STALL), 1);
      tick();
    end
    chk("mc_fwd_sel", sel(0), 3);
    chk("mc_fwd_stall", int'(STALL), 0);
    chk("mc_fwd_busy", int'(SB_BUSY), 1);
    tick();
    chk("mc_done_sel", sel(0), 0);
    chk("mc_done_busy", int'(SB_BUSY), 0);

    // WAW: lat 6 then lat 2 on x9
    clr();
    MC_ISSUE = 1; MC_RD = 5'd9; MC_LAT = 4'd6;
    tick();
    MC_LAT = 4'd2;
    #1 chk("waw_stall", int'(STALL), 1);
    tick();
    MC_ISSUE = 0;
    src(0, 5'd9, 1);
    tick();
    chk("waw_noreload_stall", int'(STALL), 1);
    chk("waw_noreload_sel", sel(0), 0);
    tick(); tick(); tick();
    chk("waw_fwd_sel", sel(0), 3);
    chk("waw_fwd_stall", int'(STALL), 0);
    tick();
    chk("waw_done_busy", int'(SB_BUSY), 0);

    // x0 issue is ignored
    clr();
    MC_ISSUE = 1; MC_RD = 5'd0; MC_LAT = 4'd4;
    tick();
    MC_ISSUE = 0;
    #1 chk("x0_busy", int'(SB_BUSY), 0);

    // Latency 0 acts as 1
    MC_ISSUE = 1; MC_RD = 5'd6; MC_LAT = 4'd0;
    tick();
    MC_ISSUE = 0;
    src(0, 5'd6, 1);
    #1 chk("lat0_sel", sel(0), 3);
    chk("lat0_stall", int'(STALL), 0);
    tick();

    // Latency above MAX_LAT saturates to 8
    clr();
    MC_ISSUE = 1; MC_RD = 5'd10; MC_LAT = 4'd15;
    tick();
    MC_ISSUE = 0;
    src(2, 5'd10, 1);
    for (int c = 0; c < 7; c++) tick();
    chk("sat_sel2", sel(2), 3);
    chk("sat_stall", int'(STALL), 0);
    tick();
    chk("sat_busy", int'(SB_BUSY), 0);

    // Store-data forwarding
    clr();
    MEMREAD_WB = 1; RD_STG = {5'd4, 5'd0};
    MEMWRITE_MEM = 1; RS2_MEM = 5'd4;
    #1 chk("st_fwd", int'(FWD_ST), 1);
    MEMREAD_WB = 0;
    #1 chk("st_noload", int'(FWD_ST), 0);
    MEMREAD_WB = 1; RD_STG = '0; RS2_MEM = 5'd0;
    #1 chk("st_x0", int'(FWD_ST), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
